// File: rtl/mat_mult_seq_pkg.sv
// Shared sizes, FSM encoding and element addressing for the 5x5 matrix multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mat_mult_seq_pkg;

   localparam int N     = 5;
   localparam int W     = 8;
   localparam int ACC_W = 2*W + 3;
   localparam int NN    = N*N;
   localparam int KW    = $clog2(NN);
   localparam int IW    = $clog2(N);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One issued element travelling from the dot product to the write stage.
   typedef struct packed {
      logic          vld;
      logic [KW-1:0] k;
      logic [W-1:0]  dat;
      logic          ovf;
   } pipe_t;

   function automatic int elem_lsb(input int i, input int j);
      return (i*N + j)*W;
   endfunction

endpackage

// File: rtl/mat_mult_seq_dot_prod_core.sv
// Combinational N-term signed dot product; wraps the result to W bits and flags overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module dot_prod_core
   import mat_mult_seq_pkg::*;
(
   input  logic [N*W-1:0] row_dat,
   input  logic [N*W-1:0] col_dat,
   output logic [W-1:0]   res_dat,
   output logic           res_ovf
);

   logic signed [2*W-1:0]   row_x [N];
   logic signed [2*W-1:0]   col_x [N];
   logic signed [2*W-1:0]   prod  [N];
   logic signed [ACC_W-1:0] sum;

   // Operands widened first so the 16-bit product is exact for every W-bit pair.
   for (genvar t = 0; t < N; t++) begin : g_prod
      assign row_x[t] = {{W{row_dat[t*W+W-1]}}, row_dat[t*W +: W]};
      assign col_x[t] = {{W{col_dat[t*W+W-1]}}, col_dat[t*W +: W]};
      assign prod[t]  = row_x[t] * col_x[t];
   end

   always_comb begin
      sum = '0;
      for (int t = 0; t < N; t++) begin
         sum = sum + {{(ACC_W-2*W){prod[t][2*W-1]}}, prod[t]};
      end
   end

   // Fits in W bits exactly when every bit above the W-bit sign position matches it.
   assign res_dat = sum[W-1:0];
   assign res_ovf = !((&sum[ACC_W-1:W-1]) || !(|sum[ACC_W-1:W-1]));

endmodule

// File: rtl/mat_mult_seq.sv
// Sequences C = A x B over one shared dot-product, one (row, column) pair per cycle.
// Latency: 27 cycles from the start-accept edge to the done pulse.
// Backpressure: none; start is only sampled in IDLE and is otherwise dropped.
module mat_mult_seq
   import mat_mult_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N*N*W-1:0]  a_in,
   input  logic [N*N*W-1:0]  b_in,
   output logic              busy,
   output logic              done,
   output logic [N*N*W-1:0]  c_out,
   output logic [N*N-1:0]    ovf_map,
   output logic              ovf
);

   localparam logic [IW-1:0] IJ_LAST = IW'(N-1);
   localparam logic [KW-1:0] K_LAST  = KW'(NN-1);

   state_t              state;
   state_t              state_nxt;
   logic                accept;
   logic                issue;
   logic                last_issue;

   logic [N*N*W-1:0]    a_reg;
   logic [N*N*W-1:0]    b_reg;
   logic [IW-1:0]       i_cnt;
   logic [IW-1:0]       j_cnt;
   logic [KW-1:0]       k_cnt;

   logic [N*W-1:0]      row_vec;
   logic [N*W-1:0]      col_vec;
   logic [W-1:0]        res_dat;
   logic                res_ovf;
   pipe_t               pipe;

   assign last_issue = (k_cnt == K_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start)      state_nxt = ST_RUN;
         ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
         ST_DRAIN:                 state_nxt = ST_DONE;
         ST_DONE:                  state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      issue  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         ST_IDLE:  accept = start;
         ST_RUN: begin
            issue = 1'b1;
            busy  = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Operands are snapshotted so the decoder may move on right after acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (accept) begin
         a_reg <= a_in;
         b_reg <= b_in;
      end
   end

   // i/j wrap back to zero on the final issue so the operand select never leaves the matrix.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_cnt <= '0;
         j_cnt <= '0;
         k_cnt <= '0;
      end else if (accept) begin
         i_cnt <= '0;
         j_cnt <= '0;
         k_cnt <= '0;
      end else if (issue) begin
         k_cnt <= k_cnt + 1'b1;
         if (j_cnt == IJ_LAST) begin
            j_cnt <= '0;
            i_cnt <= (i_cnt == IJ_LAST) ? '0 : i_cnt + 1'b1;
         end else begin
            j_cnt <= j_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      row_vec = '0;
      col_vec = '0;
      for (int t = 0; t < N; t++) begin
         row_vec[t*W +: W] = a_reg[elem_lsb(int'(i_cnt), t) +: W];
         col_vec[t*W +: W] = b_reg[elem_lsb(t, int'(j_cnt)) +: W];
      end
   end

   dot_prod_core u_dot (
      .row_dat (row_vec),
      .col_dat (col_vec),
      .res_dat (res_dat),
      .res_ovf (res_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe <= '0;
      end else begin
         pipe.vld <= issue;
         pipe.k   <= k_cnt;
         pipe.dat <= res_dat;
         pipe.ovf <= res_ovf;
      end
   end

   // c_out keeps the previous result until each element is overwritten by the new run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_out   <= '0;
         ovf_map <= '0;
      end else if (accept) begin
         ovf_map <= '0;
      end else if (pipe.vld) begin
         c_out[int'(pipe.k)*W +: W] <= pipe.dat;
         ovf_map[pipe.k]            <= pipe.ovf;
      end
   end

   assign ovf = |ovf_map;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Randomised and directed checks of mat_mult_seq against a plain-arithmetic matrix model.
module tb_mat_mult_seq;

   localparam int TN = 5;
   localparam int TW = 8;
   localparam int NE = TN*TN;
   localparam int MW = NE*TW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [MW-1:0] a_in = '0;
   logic [MW-1:0] b_in = '0;
   logic          busy;
   logic          done;
   logic [MW-1:0] c_out;
   logic [NE-1:0] ovf_map;
   logic          ovf;

   int n_vec = 0;
   int n_err = 0;

   mat_mult_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .c_out   (c_out),
      .ovf_map (ovf_map),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 output logic [MW-1:0] c, output logic [NE-1:0] om);
      int s;
      logic [31:0] sv;
      c  = '0;
      om = '0;
      for (int i = 0; i < TN; i++) begin
         for (int j = 0; j < TN; j++) begin
            s = 0;
            for (int t = 0; t < TN; t++) begin
               s += int'($signed(a[(i*TN+t)*TW +: TW])) * int'($signed(b[(t*TN+j)*TW +: TW]));
            end
            sv = s;
            c[(i*TN+j)*TW +: TW] = sv[TW-1:0];
            om[i*TN+j] = (s < -128) || (s > 127);
         end
      end
   endfunction

   function automatic logic [MW-1:0] fill(input logic [TW-1:0] v);
      logic [MW-1:0] m;
      for (int e = 0; e < NE; e++) m[e*TW +: TW] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] rand_mat();
      logic [MW-1:0] m;
      for (int e = 0; e < NE; e++) m[e*TW +: TW] = 8'($urandom_range(255));
      return m;
   endfunction

   // Presents operands with start for one edge, then scrambles the inputs.
   task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = rand_mat();
      b_in  = rand_mat();
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_vec++; if (c_out !== '0) begin n_err++; $display("FAIL reset_c got=%h exp=0", c_out); end
      n_vec++; if (ovf_map !== '0) begin n_err++; $display("FAIL reset_ovf_map got=%h exp=0", ovf_map); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_identity();
      logic [MW-1:0] a, b;
      int cyc;
      a = '0;
      b = '0;
      for (int i = 0; i < TN; i++) begin
         a[(i*TN+i)*TW +: TW] = 8'd1;
         for (int j = 0; j < TN; j++) b[(i*TN+j)*TW +: TW] = 8'(i*TN+j);
      end
      launch(a, b);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ident_busy_after_start got=%b exp=1", busy); end
      wait_done(cyc);
      n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL ident_latency got=%0d exp=26 edges after accept", cyc); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ident_busy_at_done got=%b exp=0", busy); end
      n_vec++; if (c_out !== b) begin n_err++; $display("FAIL ident_c got=%h exp=%h", c_out, b); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ident_ovf got=%b exp=0", ovf); end
      @(posedge clk);
      #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL ident_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_patterns();
      logic [MW-1:0] pa [5];
      logic [MW-1:0] pb [5];
      logic [MW-1:0] pc [5];
      logic [NE-1:0] po [5];
      int cyc;
      pa[0] = fill(8'h01); pb[0] = fill(8'h01); pc[0] = fill(8'h05); po[0] = '0;
      pa[1] = fill(8'h7F); pb[1] = fill(8'h7F); pc[1] = fill(8'h05); po[1] = '1;
      pa[2] = fill(8'hFF); pb[2] = fill(8'h01); pc[2] = fill(8'hFB); po[2] = '0;
      pa[3] = '0; pa[3][7:0] = 8'h80; pb[3] = '0; pb[3][7:0] = 8'h01;
      pc[3] = '0; pc[3][7:0] = 8'h80; po[3] = '0;
      pa[4] = pa[3]; pb[4] = '0; pb[4][7:0] = 8'hFF;
      pc[4] = pc[3]; po[4] = '0; po[4][0] = 1'b1;
      for (int p = 0; p < 5; p++) begin
         launch(pa[p], pb[p]);
         wait_done(cyc);
         n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL pat%0d_timeout got=%b exp=1", p, done); end
         n_vec++; if (c_out !== pc[p]) begin n_err++; $display("FAIL pat%0d_c got=%h exp=%h", p, c_out, pc[p]); end
         n_vec++; if (ovf_map !== po[p]) begin n_err++; $display("FAIL pat%0d_ovf_map got=%h exp=%h", p, ovf_map, po[p]); end
         n_vec++; if (ovf !== (|po[p])) begin n_err++; $display("FAIL pat%0d_ovf got=%b exp=%b", p, ovf, |po[p]); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random();
      logic [MW-1:0] a, b, ec;
      logic [NE-1:0] eo;
      int cyc;
      for (int r = 0; r < 6; r++) begin
         a = rand_mat();
         b = rand_mat();
         if (r == 0) begin
            a = '0;
            for (int e = 0; e < NE; e++) a[e*TW +: TW] = 8'($urandom_range(7));
         end
         model(a, b, ec, eo);
         launch(a, b);
         wait_done(cyc);
         n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL rnd%0d_latency got=%0d exp=26", r, cyc); end
         n_vec++; if (c_out !== ec) begin n_err++; $display("FAIL rnd%0d_c got=%h exp=%h", r, c_out, ec); end
         n_vec++; if (ovf_map !== eo) begin n_err++; $display("FAIL rnd%0d_ovf_map got=%h exp=%h", r, ovf_map, eo); end
         n_vec++; if (ovf !== (|eo)) begin n_err++; $display("FAIL rnd%0d_ovf got=%b exp=%b", r, ovf, |eo); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_start_during_run();
      logic [MW-1:0] a, b, ec;
      logic [NE-1:0] eo;
      int cyc, extra;
      a = rand_mat();
      b = rand_mat();
      model(a, b, ec, eo);
      launch(a, b);
      cyc = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      while (done !== 1'b1 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL midstart_latency got=%0d exp=26", cyc); end
      n_vec++; if (c_out !== ec) begin n_err++; $display("FAIL midstart_c got=%h exp=%h", c_out, ec); end
      extra = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_vec++; if (extra !== 0) begin n_err++; $display("FAIL midstart_extra_run got=%0d exp=0 busy/done cycles", extra); end
   endtask

   task automatic test_reset_mid_run();
      launch(rand_mat(), rand_mat());
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
      n_vec++; if (c_out !== '0) begin n_err++; $display("FAIL midrst_c got=%h exp=0", c_out); end
      n_vec++; if (ovf_map !== '0) begin n_err++; $display("FAIL midrst_ovf_map got=%h exp=0", ovf_map); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_after_reset();
      logic [MW-1:0] a, b, ec;
      logic [NE-1:0] eo;
      int cyc;
      a = rand_mat();
      b = rand_mat();
      model(a, b, ec, eo);
      launch(a, b);
      wait_done(cyc);
      n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL postrst_latency got=%0d exp=26", cyc); end
      n_vec++; if (c_out !== ec) begin n_err++; $display("FAIL postrst_c got=%h exp=%h", c_out, ec); end
      n_vec++; if (ovf_map !== eo) begin n_err++; $display("FAIL postrst_ovf_map got=%h exp=%h", ovf_map, eo); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [MW-1:0] a1, b1, a2, b2, ec;
      logic [NE-1:0] eo;
      int cyc;
      a1 = rand_mat(); b1 = rand_mat();
      a2 = rand_mat(); b2 = rand_mat();
      a_in  = a1;
      b_in  = b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      wait_done(cyc);
      model(a1, b1, ec, eo);
      n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=26", cyc); end
      n_vec++; if (c_out !== ec) begin n_err++; $display("FAIL b2b_first_c got=%h exp=%h", c_out, ec); end
      a_in = a2;
      b_in = b2;
      @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got=busy%b/done%b exp=0/0", busy, done); end
      @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got=%b exp=1", busy); end
      start = 1'b0;
      a_in  = rand_mat();
      b_in  = rand_mat();
      wait_done(cyc);
      model(a2, b2, ec, eo);
      n_vec++; if (cyc !== 26) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=26", cyc); end
      n_vec++; if (c_out !== ec) begin n_err++; $display("FAIL b2b_second_c got=%h exp=%h", c_out, ec); end
      n_vec++; if (ovf_map !== eo) begin n_err++; $display("FAIL b2b_second_ovf_map got=%h exp=%h", ovf_map, eo); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_patterns();
      test_random();
      test_start_during_run();
      test_reset_mid_run();
      test_after_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
- Sequencer for 5x5 signed 8-bit matrix multiplication, C = A x B, using one shared inner-product datapath.
- Streams one (row i of A, column j of B) pair per cycle into a one-stage registered dot-product, then writes each result into the C register.
- Reports overflow per element and as a sticky summary.
- Sits between the coprocessor instruction decoder and the matrix register file; start/busy/done handshake.

Parameters:
- N, 5, matrix dimension (rows = cols).
- W, 8, element width, two's complement.
- ACC_W, 2*W+3 = 19, internal signed accumulator width for the sum of N products.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset: clears all state while low.
- start  in  1  request; sampled only in IDLE.
- a_in  in  N*N*W  matrix A; element (i,j) at bits [(i*N+j)*W +: W].
- b_in  in  N*N*W  matrix B; same layout.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; c_out/ovf valid from this cycle.
- c_out  out  N*N*W  result matrix; same layout; held until next accepted start.
- ovf_map  out  N*N  bit (i*N+j) set if element (i,j) overflowed.
- ovf  out  1  OR of ovf_map.

Behaviour:
- Reset (rst low): state=IDLE; busy=0, done=0, c_out=0, ovf_map=0, ovf=0, counters and pipe cleared. Takes effect immediately, including mid-run; the partial result is discarded.
- FSM states:
  - IDLE: start=1 captures a_in/b_in into internal A/B registers, clears ovf_map, sets k=0, then goes to RUN. c_out keeps its old value until overwritten.
  - RUN: each cycle issues index k (i=k/N, j=k%N; use i/j counters with wrap, no divider).
    - Row i of A and column j of B go to the dot-product.
    - Pipe register captures the sum and k. k increments.
    - After k=N*N-1 is issued, go to DRAIN.
  - DRAIN: last pipe entry written, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Write stage: on every cycle the pipe is valid, c_out[k] gets the low W bits of the sum and ovf_map[k] gets the overflow flag.
- Timing: start accepted at edge E0. Issues at E1..E25, writes at E2..E26. done is high in the cycle after E26. Total 27 cycles from start edge to done.
- Arithmetic:
  - Products are signed WxW, sign-extended to ACC_W and summed in full precision.
  - Overflow = sum < -2^(W-1) or sum > 2^(W-1)-1.
  - Output is truncated (wraps), not saturated.
- start while busy or in DONE: ignored, no queuing. Inputs a_in/b_in may change freely after acceptance.
- start held high continuously: a new run begins from IDLE the cycle after done.

Decomposition:
- Shared package: N, W, ACC_W, the element-index macro/function (i*N+j)*W, and FSM state encoding (IDLE, RUN, DRAIN, DONE).
- One sub-module, dot_prod_core: combinational N-term signed dot product of packed row/column vectors.
  - Outputs the truncated W-bit result and an overflow flag.
  - The sequencer holds the pipe register and all control.

Test Plan:
- A=identity, B[i][j]=i*N+j -> after 27 cycles, c_out==B, ovf=0, done pulses once.
- A=all 1, B=all 1 -> every c_out element 0x05, ovf_map=0.
- A=all 127, B=all 127 (sum 80645) -> every element 0x05, ovf_map=all ones, ovf=1.
- A=all -1, B=all 1 -> every element 0xFB (-5), ovf=0.
- A only (0,0)=-128, B only (0,0)=1 -> c(0,0)=0x80, no ovf. Repeat with B(0,0)=-1 -> c(0,0)=0x80, ovf_map bit0=1, ovf=1.
- Control cases:
  - Pulse start again at cycle 10 of a run -> ignored, single done at cycle 27.
  - Drop rst at cycle 12 -> all outputs 0 immediately.
  - Fresh start after reset -> correct result.
